// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer for the multi-cycle FRiscV core; one outstanding imem request, one-entry instruction buffer.
// Latency: first request 1 cycle after reset release; instruction visible 1 cycle after imem ack.
// Backpressure: stall_in gates new requests only; a full buffer blocks the next request until decode drains it.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   stall_in              hold off issuing a new fetch
//   redirect_in/_addr_in  one-cycle branch/jump redirect and its target
//   imem_*                request/address out, ack/rdata in (rdata valid with ack)
//   instr_*               buffered instruction, its PC, valid/ready handshake with decode
//   pc_out                current fetch PC
//   fetch_cnt_out         delivered-instruction count; live only when FRISCV_FETCH_PERF_EN is defined
module fetch_ctrl #(
  parameter int                   PC_WIDTH    = 32,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_ADDR  = '0,
  parameter int                   WORD_BYTES  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_in,
  input  logic                   redirect_in,
  input  logic [PC_WIDTH-1:0]    redirect_addr_in,
  output logic                   imem_req_out,
  output logic [PC_WIDTH-1:0]    imem_addr_out,
  input  logic                   imem_ack_in,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
  output logic                   instr_valid_out,
  input  logic                   instr_ready_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [31:0]            fetch_cnt_out
);

  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(WORD_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_INC - PC_WIDTH'(1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic [PC_WIDTH-1:0]     pc_r;
  logic [PC_WIDTH-1:0]     hold_addr;
  logic                    flush_pend;
  logic                    req_r;
  logic                    valid_r;
  logic [INSTR_WIDTH-1:0]  instr_r;
  logic [PC_WIDTH-1:0]     ipc_r;
  logic [PC_WIDTH-1:0]     redirect_pc;

  assign redirect_pc = redirect_addr_in & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_r       <= RESET_ADDR;
      hold_addr  <= '0;
      flush_pend <= 1'b0;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      instr_r    <= '0;
      ipc_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_in) pc_r <= redirect_pc;
          if (!stall_in) begin
            state <= REQ;
            req_r <= 1'b1;
          end
        end

        REQ: begin
          if (redirect_in) begin
            pc_r <= redirect_pc;
            if (imem_ack_in) begin
              // Returning data belongs to the old path; drop it and move on.
              flush_pend <= 1'b0;
              state      <= stall_in ? IDLE : REQ;
              req_r      <= !stall_in;
            end else begin
              // The request in flight must complete on its original address,
              // so freeze it before pc_r moves. A repeat redirect keeps the
              // first frozen address and still needs only one discard.
              flush_pend <= 1'b1;
              if (!flush_pend) hold_addr <= pc_r;
            end
          end else if (imem_ack_in) begin
            if (flush_pend) begin
              flush_pend <= 1'b0;
              state      <= stall_in ? IDLE : REQ;
              req_r      <= !stall_in;
            end else begin
              instr_r <= imem_rdata_in;
              ipc_r   <= pc_r;
              valid_r <= 1'b1;
              pc_r    <= pc_r + PC_INC;
              state   <= DRAIN;
              req_r   <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (redirect_in) begin
            // Buffered instruction is on the wrong path: kill it even if
            // decode is ready this cycle.
            pc_r    <= redirect_pc;
            valid_r <= 1'b0;
            state   <= stall_in ? IDLE : REQ;
            req_r   <= !stall_in;
          end else if (instr_ready_in) begin
            valid_r <= 1'b0;
            state   <= stall_in ? IDLE : REQ;
            req_r   <= !stall_in;
          end
        end

        default: begin
          state <= IDLE;
          req_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out    = req_r;
  assign imem_addr_out   = flush_pend ? hold_addr : pc_r;
  assign instr_valid_out = valid_r;
  assign instr_out       = instr_r;
  assign instr_pc_out    = ipc_r;
  assign pc_out          = pc_r;

`ifdef FRISCV_FETCH_PERF_EN
  logic [31:0] cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (valid_r && instr_ready_in && !redirect_in) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign fetch_cnt_out = cnt_r;
`else
  assign fetch_cnt_out = '0;
`endif

endmodule
